// File: rtl/control_pkg.sv
// control_pkg: shared types for the pipeline hazard / forwarding controller.
//   fwd_sel_e  - EX operand source select (register file, MEM-stage result,
//                WB-stage result)
//   inflight_t - one scoreboard slot describing an in-flight producer
//   src_hit()  - does a decode-stage source depend on a given slot
package control_pkg;

  localparam int RF_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] rd;
    logic                 wen;   // already excludes rd == x0
    logic                 load;
  } inflight_t;

  // x0 is hard-wired zero, so a read of x0 never depends on anything.
  function automatic logic src_hit(input logic                 use_src,
                                   input logic [RF_ADDR_W-1:0] idx,
                                   input inflight_t            slot);
    return use_src && (idx != '0) && slot.valid && slot.wen && (slot.rd == idx);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: saturating event counter.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, clears the count
//   inc  - count one event this cycle
//   clr  - synchronous clear, wins over inc
//   cnt  - current count, holds at all-ones
module hazard_perf_cnt #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and forwarding controller for a five-stage pipeline.
// Tracks the destinations of the instructions in EX and MEM, raises stall /
// flush for the front end, and registers EX operand-forwarding selects.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   D_*                      - the instruction currently in ID
//   ex_redirect              - taken branch/jump resolved in EX this cycle
//   cnt_clr                  - synchronous clear of the performance counters
//   stall_if, stall_id       - hold PC and IF/ID
//   flush_id, flush_ex       - bubble into IF/ID, ID/EX
//   fwd_a_sel, fwd_b_sel     - EX operand sources (fwd_sel_e encoding)
//   stall_cnt, flush_cnt,
//   fwd_cnt                  - saturating event counters
module pipe_hazard_ctrl
  import control_pkg::*;
#(
  parameter bit FWD_EN     = 1'b1,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  D_valid,
  input  logic [REG_ADDR_W-1:0] D_rs1,
  input  logic [REG_ADDR_W-1:0] D_rs2,
  input  logic                  D_use_rs1,
  input  logic                  D_use_rs2,
  input  logic [REG_ADDR_W-1:0] D_rd,
  input  logic                  D_regwen,
  input  logic                  D_is_load,
  input  logic                  ex_redirect,
  input  logic                  cnt_clr,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  flush_id,
  output logic                  flush_ex,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  flush_cnt,
  output logic [CNT_WIDTH-1:0]  fwd_cnt
);

  if (REG_ADDR_W != RF_ADDR_W) begin : g_bad_width
    $error("pipe_hazard_ctrl: REG_ADDR_W must equal control_pkg::RF_ADDR_W");
  end

  // Only the EX and MEM slots are stored: the register file writes through in
  // the same cycle, so an instruction leaving MEM can no longer cause a hazard
  // and its slot would never be consulted.
  inflight_t ex_q, ex_d;
  inflight_t mem_q, mem_d;
  fwd_sel_e  fwd_a_q, fwd_a_d;
  fwd_sel_e  fwd_b_q, fwd_b_d;

  logic     hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
  logic     stall_raw, stall, bubble;
  fwd_sel_e sel_a, sel_b;

  assign hit_ex_a  = src_hit(D_use_rs1, D_rs1, ex_q);
  assign hit_ex_b  = src_hit(D_use_rs2, D_rs2, ex_q);
  assign hit_mem_a = src_hit(D_use_rs1, D_rs1, mem_q);
  assign hit_mem_b = src_hit(D_use_rs2, D_rs2, mem_q);

  always_comb begin
    stall_raw = 1'b0;
    sel_a     = FWD_RF;
    sel_b     = FWD_RF;
    if (FWD_EN) begin
      // Only a load in EX cannot be forwarded yet: its data exists in WB only.
      stall_raw = D_valid && ex_q.load && (hit_ex_a || hit_ex_b);
      // EX slot is the youngest producer, so it is checked first.
      if (hit_ex_a)       sel_a = FWD_MEM;
      else if (hit_mem_a) sel_a = FWD_WB;
      if (hit_ex_b)       sel_b = FWD_MEM;
      else if (hit_mem_b) sel_b = FWD_WB;
    end else begin
      stall_raw = D_valid && (hit_ex_a || hit_ex_b || hit_mem_a || hit_mem_b);
    end
  end

  // A redirect squashes the instruction in ID, so its hazard is irrelevant.
  assign stall  = stall_raw && !ex_redirect;
  assign bubble = ex_redirect || stall || !D_valid;

  always_comb begin
    mem_d   = ex_q;
    ex_d    = '0;
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (!bubble) begin
      ex_d.valid = 1'b1;
      ex_d.rd    = D_rd;
      ex_d.wen   = D_regwen && (D_rd != '0);
      ex_d.load  = D_is_load;
      fwd_a_d    = sel_a;
      fwd_b_d    = sel_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  // Control outputs are combinational, so they are gated by rst directly to
  // stay quiet for the whole reset pulse.
  assign stall_if  = stall && !rst;
  assign stall_id  = stall && !rst;
  assign flush_id  = ex_redirect && !rst;
  assign flush_ex  = (ex_redirect || stall) && !rst;
  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;

  logic fwd_inc;
  assign fwd_inc = !bubble && ((sel_a != FWD_RF) || (sel_b != FWD_RF));

  hazard_perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk (clk), .rst (rst), .inc (stall),       .clr (cnt_clr), .cnt (stall_cnt)
  );

  hazard_perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk (clk), .rst (rst), .inc (ex_redirect), .clr (cnt_clr), .cnt (flush_cnt)
  );

  hazard_perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_fwd_cnt (
    .clk (clk), .rst (rst), .inc (fwd_inc),     .clr (cnt_clr), .cnt (fwd_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance with forwarding, one
// without, both with 4-bit counters, sharing the same ID-stage stimulus.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       D_valid = 1'b0;
  logic [4:0] D_rs1 = '0, D_rs2 = '0, D_rd = '0;
  logic       D_use_rs1 = 1'b0, D_use_rs2 = 1'b0, D_regwen = 1'b0, D_is_load = 1'b0;
  logic       ex_redirect = 1'b0, cnt_clr = 1'b0;

  logic       f_stall_if, f_stall_id, f_flush_id, f_flush_ex;
  logic [1:0] f_fwd_a, f_fwd_b;
  logic [3:0] f_stall_cnt, f_flush_cnt, f_fwd_cnt;
  logic       n_stall_if, n_stall_id, n_flush_id, n_flush_ex;
  logic [1:0] n_fwd_a, n_fwd_b;
  logic [3:0] n_stall_cnt, n_flush_cnt, n_fwd_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FWD_EN(1'b1), .REG_ADDR_W(5), .CNT_WIDTH(4)) u_dut_fwd (
    .clk(clk), .rst(rst), .D_valid(D_valid), .D_rs1(D_rs1), .D_rs2(D_rs2),
    .D_use_rs1(D_use_rs1), .D_use_rs2(D_use_rs2), .D_rd(D_rd), .D_regwen(D_regwen),
    .D_is_load(D_is_load), .ex_redirect(ex_redirect), .cnt_clr(cnt_clr),
    .stall_if(f_stall_if), .stall_id(f_stall_id), .flush_id(f_flush_id),
    .flush_ex(f_flush_ex), .fwd_a_sel(f_fwd_a), .fwd_b_sel(f_fwd_b),
    .stall_cnt(f_stall_cnt), .flush_cnt(f_flush_cnt), .fwd_cnt(f_fwd_cnt)
  );

  pipe_hazard_ctrl #(.FWD_EN(1'b0), .REG_ADDR_W(5), .CNT_WIDTH(4)) u_dut_nofwd (
    .clk(clk), .rst(rst), .D_valid(D_valid), .D_rs1(D_rs1), .D_rs2(D_rs2),
    .D_use_rs1(D_use_rs1), .D_use_rs2(D_use_rs2), .D_rd(D_rd), .D_regwen(D_regwen),
    .D_is_load(D_is_load), .ex_redirect(ex_redirect), .cnt_clr(cnt_clr),
    .stall_if(n_stall_if), .stall_id(n_stall_id), .flush_id(n_flush_id),
    .flush_ex(n_flush_ex), .fwd_a_sel(n_fwd_a), .fwd_b_sel(n_fwd_b),
    .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt), .fwd_cnt(n_fwd_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic wen, input logic ld);
    D_valid = v; D_rs1 = rs1; D_use_rs1 = u1; D_rs2 = rs2; D_use_rs2 = u2;
    D_rd = rd; D_regwen = wen; D_is_load = ld;
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    ex_redirect = 1'b0;
    cnt_clr     = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_stall_id", f_stall_id, 1'b0);
    check("rst_fwd_a", f_fwd_a, 2'b00);
    check("rst_stall_cnt", f_stall_cnt, 4'd0);

    // add x5,x1,x2 ; add x6,x5,x3 (forwarding): EX->EX forward, no stall
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0);
    check("alu_dep_no_stall", f_stall_id, 1'b0);
    check("alu_dep_no_flush_ex", f_flush_ex, 1'b0);
    step();
    idle();
    check("alu_dep_fwd_a", f_fwd_a, 2'b01);
    check("alu_dep_fwd_b", f_fwd_b, 2'b00);
    check("alu_dep_fwd_cnt", f_fwd_cnt, 4'd1);

    // lw x5,0(x1) ; add x6,x1,x5 (forwarding): one stall then WB forward
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    check("ld_use_stall_id", f_stall_id, 1'b1);
    check("ld_use_stall_if", f_stall_if, 1'b1);
    check("ld_use_flush_ex", f_flush_ex, 1'b1);
    check("ld_use_flush_id", f_flush_id, 1'b0);
    step();
    check("ld_use_released", f_stall_id, 1'b0);
    check("ld_use_bubble_sel", f_fwd_b, 2'b00);
    step();
    idle();
    check("ld_use_fwd_b", f_fwd_b, 2'b10);
    check("ld_use_fwd_a", f_fwd_a, 2'b00);
    check("ld_use_stall_cnt", f_stall_cnt, 4'd1);

    // add x5 ; add x6,x5,x5 without forwarding: two stalls
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    check("nofwd_stall1", n_stall_id, 1'b1);
    step();
    check("nofwd_stall2", n_stall_id, 1'b1);
    step();
    check("nofwd_released", n_stall_id, 1'b0);
    step();
    idle();
    check("nofwd_sel_a", n_fwd_a, 2'b00);
    check("nofwd_sel_b", n_fwd_b, 2'b00);
    check("nofwd_stall_cnt", n_stall_cnt, 4'd2);
    check("nofwd_fwd_cnt", n_fwd_cnt, 4'd0);

    // Without forwarding, one independent instruction in between: one stall
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    check("gap1_stall", n_stall_id, 1'b1);
    step();
    check("gap1_released", n_stall_id, 1'b0);
    step();
    idle();
    check("gap1_stall_cnt", n_stall_cnt, 4'd3);

    // Producer writes x0, consumer reads x0: never a hazard
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
    check("x0_fwd_no_stall", f_stall_id, 1'b0);
    check("x0_nofwd_no_stall", n_stall_id, 1'b0);
    step();
    idle();
    check("x0_fwd_sel_a", f_fwd_a, 2'b00);
    check("x0_fwd_sel_b", f_fwd_b, 2'b00);

    // Redirect in the same cycle as a load-use hit: flush wins
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    ex_redirect = 1'b1;
    #1;
    check("redir_flush_id", f_flush_id, 1'b1);
    check("redir_flush_ex", f_flush_ex, 1'b1);
    check("redir_stall_if", f_stall_if, 1'b0);
    check("redir_stall_id", f_stall_id, 1'b0);
    step();
    ex_redirect = 1'b0;
    idle();
    check("redir_flush_cnt", f_flush_cnt, 4'd1);
    check("redir_stall_cnt", f_stall_cnt, 4'd0);

    // Reset pulsed mid-stall: add x5 ; lw x7,0(x5) ; add x8,x7,x0
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
    check("pre_rst_stall", f_stall_id, 1'b1);
    check("pre_rst_fwd_a", f_fwd_a, 2'b01);
    check("pre_rst_fwd_cnt", f_fwd_cnt, 4'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_stall_id", f_stall_id, 1'b0);
    check("mid_rst_flush_ex", f_flush_ex, 1'b0);
    check("mid_rst_fwd_a", f_fwd_a, 2'b00);
    check("mid_rst_fwd_cnt", f_fwd_cnt, 4'd0);
    check("mid_rst_flush_cnt", f_flush_cnt, 4'd0);
    #2;
    rst = 1'b0;
    #1;
    check("post_rst_no_stall", f_stall_id, 1'b0);

    // Saturation at 4'hF, then synchronous clear beats increment
    do_reset();
    ex_redirect = 1'b1;
    for (int i = 0; i < 17; i++) step();
    check("sat_flush_cnt", f_flush_cnt, 4'hF);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    ex_redirect = 1'b0;
    #1;
    check("clr_flush_cnt", f_flush_cnt, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
